// File: rtl/pio_pkg.sv
// Shared constants for the debounced input PIO: register word offsets and address width.
package pio_pkg;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] REG_RISE_EN  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] REG_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] REG_FALL_EN  = 3'd4;
  localparam logic [ADDR_W-1:0] REG_RAW      = 3'd5;
endpackage

// File: rtl/pio_debounced_in_debounce_bit.sv
// One input channel: 2-flop synchroniser, saturating debounce counter and stable level,
// with a single-cycle strobe on the cycle the stable level is replaced.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic sync_o,
  output logic stable_o,
  output logic update_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while sync2 disagrees with stable; any agreement restarts it.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    update_o = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        update_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync2_q;
  assign stable_o = stable_q;
endmodule

// File: rtl/pio_debounced_in.sv
// Debounced multi-channel edge-capture input PIO on Avalon-MM: register file,
// per-channel edge enables, W1C capture flags, registered read mux and level irq.
module pio_debounced_in
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  logic [WIDTH-1:0] raw, stable, upd, rise, fall;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] wdata, clr;
  logic             wr;
  logic             unused_wdata;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_ch
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (IDLE_LEVEL)
      ) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .din_i   (in_port[i]),
        .sync_o  (raw[i]),
        .stable_o(stable[i]),
        .update_o(upd[i])
      );
      // On an update stable takes sync2's value, so sync2 gives the edge direction.
      assign rise[i] = upd[i] &  raw[i];
      assign fall[i] = upd[i] & ~raw[i];
    end
  endgenerate

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign clr          = (wr && address == REG_EDGE_CAP) ? wdata : '0;

  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      case (address)
        REG_RISE_EN:  rise_en_d  = wdata;
        REG_FALL_EN:  fall_en_d  = wdata;
        REG_IRQ_MASK: irq_mask_d = wdata;
        default: ;
      endcase
    end
    // Set is applied after clear so a coincident W1C cannot drop an edge.
    edge_cap_d = (edge_cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      REG_DATA:     readdata_d[WIDTH-1:0] = stable;
      REG_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
      REG_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      REG_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      REG_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
      REG_RAW:      readdata_d[WIDTH-1:0] = raw;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);
endmodule

// File: tb/tb_pio_debounced_in.sv
// Directed bench for pio_debounced_in (WIDTH=4, DEBOUNCE_CYCLES=8) with a read scoreboard.
module tb_pio_debounced_in;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  pio_debounced_in #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .IDLE_LEVEL(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got readdata %h, required a queued expectation", readdata);
    end else begin
      e = sb.pop_front();
      assert (readdata === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, readdata, e.exp);
      end
    end
  endtask

  task automatic check_irq(input string tag, input logic exp);
    n_chk++;
    assert (irq === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got irq %b expected %b", tag, irq, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    expect_rd(tag, exp);
    tick();
    check_rd();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;
    repeat (3) tick();
    expect_rd("rst_readdata", 32'h0);
    check_rd();
    check_irq("rst_irq", 1'b0);
    reset_n = 1'b1;
    tick();

    // Reset values
    rd(3'd0, 32'hF, "rst_data");
    rd(3'd4, 32'hF, "rst_fall_en");
    rd(3'd1, 32'h0, "rst_rise_en");
    rd(3'd2, 32'h0, "rst_irq_mask");
    rd(3'd3, 32'h0, "rst_edge_cap");
    rd(3'd5, 32'hF, "rst_raw");
    rd(3'd6, 32'h0, "addr6_zero");
    check_irq("rst_irq_after", 1'b0);

    // 5-cycle glitch on ch0 is rejected
    in_port = 4'hE;
    repeat (5) tick();
    in_port = 4'hF;
    repeat (20) tick();
    rd(3'd0, 32'hF, "glitch_data");
    rd(3'd3, 32'h0, "glitch_edge_cap");

    // Accepted fall on ch0: stable updates 10 edges after the pin change
    wr(3'd2, 32'h1);
    address = 3'd0;
    in_port = 4'hE;
    repeat (9) tick();
    check_irq("fall0_irq_early", 1'b0);
    expect_rd("fall0_data_e10", 32'hF);
    tick();
    check_rd();
    check_irq("fall0_irq_set", 1'b1);
    expect_rd("fall0_data_e11", 32'hE);
    tick();
    check_rd();
    rd(3'd3, 32'h1, "fall0_edge_cap");
    wr(3'd3, 32'h1);
    check_irq("w1c_irq_clear", 1'b0);
    rd(3'd3, 32'h0, "w1c_edge_cap");

    // Rise on ch0 with RISE_EN clear is not captured
    in_port = 4'hF;
    repeat (12) tick();
    rd(3'd3, 32'h0, "rise0_disabled");
    rd(3'd0, 32'hF, "rise0_data");

    // Rise-only on ch1
    wr(3'd1, 32'h2);
    wr(3'd4, 32'h0);
    in_port = 4'hD;
    repeat (20) tick();
    rd(3'd3, 32'h0, "fall1_disabled");
    rd(3'd0, 32'hD, "fall1_data");
    address = 3'd3;
    in_port = 4'hF;
    expect_rd("rise1_not_yet", 32'h0);
    repeat (10) tick();
    check_rd();
    expect_rd("rise1_captured", 32'h2);
    tick();
    check_rd();
    check_irq("rise1_masked", 1'b0);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, "rise1_w1c");

    // W1C on the exact accept cycle of ch2's fall: set wins
    wr(3'd4, 32'h4);
    in_port = 4'hB;
    repeat (9) tick();
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h4, "set_wins");
    check_irq("set_wins_masked", 1'b0);
    wr(3'd2, 32'h4);
    check_irq("mask_on_irq", 1'b1);
    wr(3'd2, 32'h0);
    check_irq("mask_off_irq", 1'b0);
    rd(3'd3, 32'h4, "mask_keeps_cap");
    wr(3'd3, 32'h0);
    rd(3'd3, 32'h4, "w1c_zero_keeps");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "w1c_ch2");
    in_port = 4'hF;
    repeat (12) tick();
    rd(3'd3, 32'h0, "rise2_disabled");

    // Reset mid-count on ch3 (counter reaches 5 after the 7th edge)
    in_port = 4'h7;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    expect_rd("midrst_readdata", 32'h0);
    check_rd();
    check_irq("midrst_irq", 1'b0);
    in_port = 4'hF;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (15) tick();
    rd(3'd0, 32'hF, "midrst_data");
    rd(3'd3, 32'h0, "midrst_no_edge");
    rd(3'd4, 32'hF, "midrst_fall_en");

    // Counter restarts from zero: a full 10 edges are needed again
    address = 3'd3;
    in_port = 4'h7;
    expect_rd("ch3_not_yet", 32'h0);
    repeat (10) tick();
    check_rd();
    expect_rd("ch3_captured", 32'h8);
    tick();
    check_rd();
    rd(3'd5, 32'h7, "raw_ch3");
    wr(3'd0, 32'hF);
    rd(3'd0, 32'h7, "data_ro");
    wr(3'd6, 32'hF);
    rd(3'd6, 32'h0, "addr6_write_ignored");

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
